// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch and PC sequencing for the Minisys core.
//
// Fetches one instruction at a time over a req/ack handshake, then holds it
// for decode/execute until exec_done resolves it. The next PC is then selected
// from jr / j / jal / conditional-branch / fall-through.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction memory handshake (addr = PC)
//   Instruction, instr_valid  latched instruction and its valid flag
//   PC, PC_plus_4             current instruction address and PC + 4
//   link_addr                 return address written by jal
//   exec_done                 one-cycle pulse: flags below are valid this cycle
//   Addr_Result, Zero         branch target and condition from execute
//   Branch/nBranch/Jmp/Jal/Jr control flags; Read_data_1 is the jr target
//   align_err                 one-cycle pulse after loading a misaligned target
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction,
   output logic        instr_valid,
   output logic [31:0] PC,
   output logic [31:0] PC_plus_4,
   output logic [31:0] link_addr,
   input  logic        exec_done,
   input  logic [31:0] Addr_Result,
   input  logic        Zero,
   input  logic        Branch,
   input  logic        nBranch,
   input  logic        Jmp,
   input  logic        Jal,
   input  logic        Jr,
   input  logic [31:0] Read_data_1,
   output logic        align_err
);

   typedef enum logic {FETCH, ISSUE} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] link_q, link_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        align_q, align_d;
   logic [31:0] next_pc;

   assign PC_plus_4   = pc_q + 32'd4;
   assign PC          = pc_q;
   assign imem_addr   = pc_q;
   assign Instruction = instr_q;
   assign instr_valid = valid_q;
   assign link_addr   = link_q;
   assign align_err   = align_q;
   // Request is gated by reset so memory never sees a fetch while in reset.
   assign imem_req    = (state_q == FETCH) && !reset;

   // Target selection, highest priority first.
   always_comb begin
      next_pc = PC_plus_4;
      if (Jr)
         next_pc = Read_data_1;
      else if (Jmp || Jal)
         next_pc = {PC_plus_4[31:28], instr_q[25:0], 2'b00};
      else if ((Branch && Zero) || (nBranch && !Zero))
         next_pc = Addr_Result;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      link_d  = link_q;
      instr_d = instr_q;
      valid_d = valid_q;
      align_d = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (exec_done) begin
               // Low bits are dropped; a nonzero drop is flagged, not trapped.
               pc_d    = {next_pc[31:2], 2'b00};
               align_d = |next_pc[1:0];
               valid_d = 1'b0;
               if (Jal)
                  link_d = PC_plus_4;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         link_q  <= 32'd0;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         align_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         link_q  <= link_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         align_q <= align_d;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PC_plus_4;
   logic [31:0] link_addr;
   logic        exec_done;
   logic [31:0] Addr_Result;
   logic        Zero, Branch, nBranch, Jmp, Jal, Jr;
   logic [31:0] Read_data_1;
   logic        align_err;

   always #5 clock = ~clock;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .Instruction(Instruction),
      .instr_valid(instr_valid), .PC(PC), .PC_plus_4(PC_plus_4),
      .link_addr(link_addr), .exec_done(exec_done),
      .Addr_Result(Addr_Result), .Zero(Zero), .Branch(Branch),
      .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
      .Read_data_1(Read_data_1), .align_err(align_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An instruction is either awaiting fetch (m_held = 0) or held for execution.
   logic [31:0] m_pc, m_link, m_instr;
   logic        m_held, m_align;

   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] ins);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      if (Jr) return Read_data_1;
      if (Jmp || Jal) return {p4[31:28], ins[25:0], 2'b00};
      if ((Branch && Zero) || (nBranch && !Zero)) return Addr_Result;
      return p4;
   endfunction

   task automatic model_step();
      logic [31:0] t;
      if (reset) begin
         m_pc = 32'h0; m_link = 32'h0; m_instr = 32'h0; m_held = 1'b0; m_align = 1'b0;
      end else begin
         m_align = 1'b0;
         if (!m_held) begin
            if (imem_ack) begin
               m_instr = imem_rdata;
               m_held  = 1'b1;
            end
         end else if (exec_done) begin
            t = ref_target(m_pc, m_instr);
            if (Jal) m_link = m_pc + 32'd4;
            m_align = (t % 4) != 0;
            m_pc    = t - (t % 4);
            m_held  = 1'b0;
         end
      end
   endtask

   task automatic model_check();
      chk("m_req",   {31'd0, imem_req},    {31'd0, !m_held && !reset});
      chk("m_addr",  imem_addr,            m_pc);
      chk("m_pc",    PC,                   m_pc);
      chk("m_pc4",   PC_plus_4,            m_pc + 32'd4);
      chk("m_instr", Instruction,          m_instr);
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_held});
      chk("m_link",  link_addr,            m_link);
      chk("m_align", {31'd0, align_err},   {31'd0, m_align});
   endtask

   // Inputs are set one time unit after a rising edge; tick checks the
   // settled outputs, advances the model, and crosses the next edge.
   task automatic tick();
      #1;
      model_check();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_in();
      imem_ack = 0; imem_rdata = 0; exec_done = 0; Addr_Result = 0; Zero = 0;
      Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Read_data_1 = 0;
   endtask

   task automatic fetch_ack(input logic [31:0] ins);
      clr_in(); imem_ack = 1; imem_rdata = ins; tick();
   endtask

   task automatic exec_jr(input logic [31:0] tgt);
      clr_in(); exec_done = 1; Jr = 1; Read_data_1 = tgt; tick(); clr_in();
   endtask

   // ---------------- directed next-PC table ----------------
   typedef struct {
      logic [31:0] pc, instr, ar, rd1;
      logic        br, nbr, zero, jmp, jal, jr;
      logic [31:0] exp_pc;
      logic        exp_align;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] pc, ins, ar, rd1,
                               input logic br, nbr, zero, jmp, jal, jr,
                               input logic [31:0] exp_pc, input logic exp_align);
      vec_t v;
      v.pc = pc; v.instr = ins; v.ar = ar; v.rd1 = rd1;
      v.br = br; v.nbr = nbr; v.zero = zero; v.jmp = jmp; v.jal = jal; v.jr = jr;
      v.exp_pc = exp_pc; v.exp_align = exp_align;
      return v;
   endfunction

   vec_t tbl[12];

   initial begin
      tbl[0]  = mk(32'h10, 0, 32'h40, 0,          1,0,1, 0,0,0, 32'h40, 0);
      tbl[1]  = mk(32'h10, 0, 32'h40, 0,          1,0,0, 0,0,0, 32'h14, 0);
      tbl[2]  = mk(32'h10, 0, 32'h20, 0,          0,1,0, 0,0,0, 32'h20, 0);
      tbl[3]  = mk(32'h10, 0, 32'h20, 0,          0,1,1, 0,0,0, 32'h14, 0);
      tbl[4]  = mk(32'h1000_0008, 32'h0000_0100, 0, 0, 0,0,0, 0,1,0, 32'h1000_0400, 0);
      tbl[5]  = mk(32'h1000_0400, 0, 0, 32'h1000_000C, 0,0,0, 0,0,1, 32'h1000_000C, 0);
      tbl[6]  = mk(32'h100, 32'h0000_003F, 0, 32'h200, 0,0,0, 1,0,1, 32'h200, 0);
      tbl[7]  = mk(32'h30, 0, 0, 32'h23,          0,0,0, 0,0,1, 32'h20, 1);
      tbl[8]  = mk(32'hFFFF_FFFC, 0, 0, 0,        0,0,0, 0,0,0, 32'h0, 0);
      tbl[9]  = mk(32'h20, 32'h0000_0010, 32'h80, 0, 1,0,1, 1,0,0, 32'h40, 0);
      tbl[10] = mk(32'h50, 0, 32'h42, 0,          1,0,1, 0,0,0, 32'h40, 1);
      tbl[11] = mk(32'hF000_0000, 32'h03FF_FFFF, 0, 0, 0,0,0, 1,0,0, 32'hFFFF_FFFC, 0);
   end

   initial begin : main
      logic [31:0] rt;
      clr_in();
      reset = 1;
      @(posedge clock); #1;
      model_step();            // model follows the first reset edge
      tick(); tick();          // two more reset cycles, req must stay 0
      reset = 0;

      // Sequential fetch from the reset PC, back-to-back timing.
      for (int i = 0; i < 3; i++) begin
         clr_in(); imem_ack = 1;
         #1;
         chk("seq_addr", imem_addr, 32'(i * 4));
         chk("seq_req", {31'd0, imem_req}, 32'd1);
         tick();
         clr_in(); exec_done = 1;
         #1;
         chk("seq_valid", {31'd0, instr_valid}, 32'd1);
         chk("seq_pc4", PC_plus_4, 32'(i * 4 + 4));
         tick();
         chk("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
      end

      // Wait-state handshake: three idle cycles then ack.
      clr_in(); imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ws_req", {31'd0, imem_req}, 32'd1);
         chk("ws_addr", imem_addr, 32'hC);
         chk("ws_instr_held", Instruction, 32'h0);
         tick();
      end
      imem_ack = 1;
      #1;
      chk("ws_req_ack", {31'd0, imem_req}, 32'd1);
      chk("ws_addr_ack", imem_addr, 32'hC);
      tick();
      chk("ws_instr", Instruction, 32'hDEAD_BEEF);
      clr_in(); imem_ack = 1; imem_rdata = 32'h1234_5678;   // ignored in ISSUE
      tick();
      chk("ws_issue_ignore", Instruction, 32'hDEAD_BEEF);
      clr_in(); exec_done = 1; tick(); clr_in();

      // Table-driven next-PC selection.
      for (int r = 0; r < 12; r++) begin
         fetch_ack(0);
         exec_jr(tbl[r].pc);
         fetch_ack(tbl[r].instr);
         clr_in();
         exec_done = 1; Addr_Result = tbl[r].ar; Read_data_1 = tbl[r].rd1;
         Branch = tbl[r].br; nBranch = tbl[r].nbr; Zero = tbl[r].zero;
         Jmp = tbl[r].jmp; Jal = tbl[r].jal; Jr = tbl[r].jr;
         if (tbl[r].pc == 32'hFFFF_FFFC) begin
            #1;
            chk("wrap_pc4", PC_plus_4, 32'h0);
         end
         tick();
         clr_in();
         chk($sformatf("tbl%0d_pc", r), PC, tbl[r].exp_pc);
         chk($sformatf("tbl%0d_align", r), {31'd0, align_err}, {31'd0, tbl[r].exp_align});
         if (tbl[r].jal) chk($sformatf("tbl%0d_link", r), link_addr, tbl[r].pc + 32'd4);
         tick();
         chk($sformatf("tbl%0d_align_pulse", r), {31'd0, align_err}, 32'd0);
      end

      // Reset in ISSUE with exec_done and jal: everything abandoned.
      fetch_ack(32'h0000_0123);
      clr_in(); reset = 1; exec_done = 1; Jal = 1; tick();
      clr_in();
      chk("rst_issue_pc", PC, 32'h0);
      chk("rst_issue_link", link_addr, 32'h0);
      chk("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
      reset = 0;

      // Reset during a pending fetch with ack.
      tick();
      reset = 1; imem_ack = 1; imem_rdata = 32'hCAFE_BABE;
      #1;
      chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("rst_fetch_instr", Instruction, 32'h0);
      chk("rst_fetch_valid", {31'd0, instr_valid}, 32'd0);
      clr_in(); reset = 0;

      // Randomized traffic checked against the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 99) == 0);
         imem_ack   = $urandom_range(0, 1);
         imem_rdata = $urandom;
         exec_done  = ($urandom_range(0, 4) < 2);
         Zero       = $urandom_range(0, 1);
         Branch     = ($urandom_range(0, 3) == 0);
         nBranch    = ($urandom_range(0, 3) == 0);
         Jmp        = ($urandom_range(0, 5) == 0);
         Jal        = ($urandom_range(0, 5) == 0);
         Jr         = ($urandom_range(0, 5) == 0);
         rt         = $urandom;
         Read_data_1 = ($urandom_range(0, 3) == 0) ? rt : {rt[31:2], 2'b00};
         rt         = $urandom;
         Addr_Result = ($urandom_range(0, 3) == 0) ? rt : {rt[31:2], 2'b00};
         tick();
      end
      clr_in(); reset = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch and PC-sequencing block of the Minisys single-issue core. It is the upstream end of the execute unit's branch interface.
- Fetches one 32-bit instruction per turn from instruction memory over a req/ack handshake and presents it to decode/execute.
- Supplies PC_plus_4 to execute. Consumes execute's Addr_Result/Zero and control's jump/branch flags to select the next PC.
- Multi-cycle; one instruction in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address (current PC)
imem_ack  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
Instruction  out  32  latched instruction for decode/execute
instr_valid  out  1  Instruction is valid and awaiting execution
PC  out  32  address of the current instruction
PC_plus_4  out  32  PC + 4, to execute unit branch adder
link_addr  out  32  return address captured on jal
exec_done  in  1  one-cycle pulse: current instruction resolved; control/branch inputs valid this cycle
Addr_Result  in  32  branch target from execute
Zero  in  1  branch condition from execute
Branch  in  1  beq
nBranch  in  1  bne
Jmp  in  1  j
Jal  in  1  jal
Jr  in  1  jr
Read_data_1  in  32  rs value, jr target
align_err  out  1  one-cycle pulse: selected target had nonzero bits [1:0]

Behaviour:
- Reset values:
  - PC = RESET_PC; link_addr = 0; Instruction = 0.
  - instr_valid = 0; imem_req = 0; align_err = 0.
  - State = FETCH.
- Outputs while reset is asserted:
  - imem_req is forced 0 combinationally.
  - An imem_ack sampled during a reset cycle is ignored.
  - Reset mid-fetch or mid-issue abandons the instruction; no PC update, no link write.
- Combinational outputs:
  - PC_plus_4 = PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - imem_addr = PC.
- State FETCH:
  - imem_req = 1. imem_addr is held stable until ack.
  - On an edge with imem_ack = 1: Instruction <= imem_rdata, instr_valid <= 1, go to ISSUE.
  - Ack in the first req cycle is legal, so minimum fetch latency is 1 cycle.
  - exec_done is ignored in FETCH.
- State ISSUE:
  - imem_req = 0. Instruction and instr_valid are held.
  - imem_ack is ignored.
  - On an edge with exec_done = 1: PC <= next_pc, instr_valid <= 0, go to FETCH.
- next_pc selection, priority highest first, evaluated only on exec_done:
  1. Jr: Read_data_1.
  2. Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch & Zero) or (nBranch & ~Zero): Addr_Result.
  4. Otherwise: PC_plus_4.
- Multiple flags asserted together resolve by the priority above; no error is raised.
- Link capture: Jal with exec_done sets link_addr <= PC_plus_4. All other cases hold link_addr.
- Alignment:
  - The PC is loaded with next_pc[31:2], 2'b00.
  - If next_pc[1:0] != 0, align_err pulses high for exactly the cycle after the update.
- Throughput:
  - One instruction per (fetch latency + 1 + execute wait) cycles.
  - Back-to-back case: ack at first req, exec_done in the first ISSUE cycle gives 2 cycles per instruction.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: hold reset 3 cycles, release; memory acks immediately; exec_done each ISSUE cycle, no flags.
  - Required: imem_addr sequence 0x0, 0x4, 0x8; PC_plus_4 = 0x4 during the first instruction; instr_valid period 2 cycles.
- Wait-state handshake:
  - Stimulus: ack delayed 3 cycles.
  - Required: imem_req and imem_addr stay stable for all 4 cycles; Instruction updates only on the ack edge.
- Branches:
  - At PC = 0x10, Branch = 1, Zero = 1, Addr_Result = 0x40: next imem_addr = 0x40.
  - Same stimulus with Zero = 0: next imem_addr = 0x14.
  - nBranch = 1, Zero = 0, Addr_Result = 0x20: next imem_addr = 0x20.
- Jumps:
  - At PC = 0x1000_0008, jal with Instruction[25:0] = 26'h100: PC becomes 0x1000_0400 and link_addr = 0x1000_000C.
  - Then Jr with Read_data_1 = 0x1000_000C: PC returns to 0x1000_000C.
  - Jr and Jmp asserted together: Jr wins.
- Alignment and wrap-around:
  - Jr with Read_data_1 = 0x23: PC = 0x20 and align_err pulses 1 cycle.
  - PC = 0xFFFF_FFFC with no flags: PC_plus_4 = 0 and the next fetch is at 0x0.
- Reset mid-operation:
  - Assert reset in ISSUE coincident with exec_done and Jal: PC = RESET_PC, link_addr = 0, instr_valid = 0.
  - Assert reset during a pending fetch with ack: Instruction stays 0 and imem_req = 0.
